// File: rtl/mem_bus_responder.sv
// mem_bus_responder: valid/ready memory responder with configurable wait states over an internal word RAM.
module mem_bus_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 8,
    parameter int DEPTH       = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES);
    state_t state, state_nxt;
    logic we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic err, fire, accept;
    assign err       = 32'(addr_q) >= DEPTH;
    assign fire      = state == WAIT && cnt == 4'd0;
    assign accept    = state == IDLE && req_valid;
    assign req_ready = state == IDLE && !rst;
    assign busy      = state != IDLE;
    always_comb begin
        state_nxt = state;
        state_nxt = accept ? WAIT : fire ? RESP : (state == RESP && rsp_ready) ? IDLE : state;
    end
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end
    // Request fields are captured only on the accept edge; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            cnt       <= 4'd0;
        end else begin
            if (accept) begin
                we_q    <= req_we;
                addr_q  <= req_addr;
                wdata_q <= req_wdata;
                cnt     <= WAIT_LD;
            end
            if (state == WAIT && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (fire) begin
                rsp_valid <= 1'b1;
                rsp_err   <= err;
                rsp_rdata <= (we_q || err) ? '0 : mem[addr_q];
            end
            if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
        end
    end
    // RAM is not reset; a reset on the access edge suppresses the write.
    always_ff @(posedge clk) begin
        if (!rst && fire && we_q && !err) mem[addr_q] <= wdata_q;
    end
endmodule

// File: tb/tb_mem_bus_responder.sv
// tb_mem_bus_responder: directed checks of handshake, latency, errors and reset recovery.
module tb_mem_bus_responder;
    logic clk = 1'b0;
    logic rst;
    logic a_req_valid, a_req_ready, a_req_we, a_rsp_valid, a_rsp_ready, a_rsp_err, a_busy;
    logic [7:0] a_req_addr;
    logic [15:0] a_req_wdata, a_rsp_rdata;
    logic b_req_valid, b_req_ready, b_req_we, b_rsp_valid, b_rsp_ready, b_rsp_err, b_busy;
    logic [7:0] b_req_addr;
    logic [15:0] b_req_wdata, b_rsp_rdata;
    int pass = 0, total = 0, cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mem_bus_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(200), .WAIT_CYCLES(2)) u_a (
        .clk(clk), .rst(rst), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err), .busy(a_busy));

    mem_bus_responder #(.DATA_W(16), .ADDR_W(8), .DEPTH(256), .WAIT_CYCLES(0)) u_b (
        .clk(clk), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .busy(b_busy));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on instance a and stop once rsp_valid is seen (rsp_ready held low).
    task automatic a_xact(input logic we, input logic [7:0] addr, input logic [15:0] wd, output int lat);
        int k;
        a_req_we = we; a_req_addr = addr; a_req_wdata = wd; a_req_valid = 1'b1; a_rsp_ready = 1'b0;
        k = 0;
        while (!a_req_ready && k < 20) begin tick(); k++; end
        tick();
        a_req_valid = 1'b0; a_req_addr = 8'hFF; a_req_wdata = 16'hFFFF; a_req_we = ~we;
        lat = 0;
        while (!a_rsp_valid && lat < 30) begin tick(); lat++; end
    endtask

    task automatic a_done();
        a_rsp_ready = 1'b1;
        tick();
        a_rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 8'h10; a_req_wdata = 16'hDEAD;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++; if (a_req_ready !== 1'b0) $display("FAIL reset_req_ready got=%b exp=0", a_req_ready); else pass++;
            total++; if (a_rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got=%b exp=0", a_rsp_valid); else pass++;
            total++; if (a_busy !== 1'b0) $display("FAIL reset_busy got=%b exp=0", a_busy); else pass++;
        end
        total++; if (a_rsp_rdata !== 16'h0 || a_rsp_err !== 1'b0)
            $display("FAIL reset_rsp got=%h/%b exp=0000/0", a_rsp_rdata, a_rsp_err); else pass++;
        rst = 1'b0; a_req_valid = 1'b0;
        #1;
        total++; if (a_req_ready !== 1'b1) $display("FAIL post_reset_ready got=%b exp=1", a_req_ready); else pass++;
        for (int i = 0; i < 4; i++) tick();
        total++; if (a_rsp_valid !== 1'b0 || a_busy !== 1'b0)
            $display("FAIL reset_no_accept got=%b/%b exp=0/0", a_rsp_valid, a_busy); else pass++;
    endtask

    task automatic test_write_read();
        int lat;
        a_xact(1'b1, 8'h10, 16'hBEEF, lat);
        total++; if (lat !== 3) $display("FAIL wr_latency got=%0d exp=3", lat); else pass++;
        total++; if (a_rsp_err !== 1'b0 || a_rsp_rdata !== 16'h0)
            $display("FAIL wr_rsp got=%b/%h exp=0/0000", a_rsp_err, a_rsp_rdata); else pass++;
        a_done();
        a_xact(1'b0, 8'h10, 16'h0, lat);
        total++; if (lat !== 3) $display("FAIL rd_latency got=%0d exp=3", lat); else pass++;
        total++; if (a_rsp_rdata !== 16'hBEEF || a_rsp_err !== 1'b0)
            $display("FAIL rd_after_wr got=%h/%b exp=beef/0", a_rsp_rdata, a_rsp_err); else pass++;
        a_done();
    endtask

    task automatic test_backpressure();
        int lat;
        a_xact(1'b0, 8'h10, 16'h0, lat);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 8'h10; a_req_wdata = 16'h0BAD;
        for (int i = 0; i < 5; i++) begin
            total++; if (a_rsp_valid !== 1'b1 || a_rsp_rdata !== 16'hBEEF || a_rsp_err !== 1'b0)
                $display("FAIL hold_rsp cyc%0d got=%b/%h/%b exp=1/beef/0", i, a_rsp_valid, a_rsp_rdata, a_rsp_err); else pass++;
            total++; if (a_req_ready !== 1'b0) $display("FAIL hold_req_ready cyc%0d got=%b exp=0", i, a_req_ready); else pass++;
            tick();
        end
        a_req_valid = 1'b0; a_rsp_ready = 1'b1;
        tick();
        a_rsp_ready = 1'b0;
        total++; if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1 || a_busy !== 1'b0)
            $display("FAIL release got=%b/%b/%b exp=0/1/0", a_rsp_valid, a_req_ready, a_busy); else pass++;
        total++; if (a_rsp_rdata !== 16'hBEEF) $display("FAIL retain_rdata got=%h exp=beef", a_rsp_rdata); else pass++;
        a_xact(1'b0, 8'h10, 16'h0, lat);
        total++; if (a_rsp_rdata !== 16'hBEEF) $display("FAIL no_accept_in_resp got=%h exp=beef", a_rsp_rdata); else pass++;
        a_done();
    endtask

    task automatic test_back_to_back();
        int k, acc, prev;
        logic [15:0] exp_d;
        b_rsp_ready = 1'b1; b_req_valid = 1'b1;
        prev = 0;
        for (int i = 0; i < 8; i++) begin
            b_req_we = (i < 4); b_req_addr = 8'(i % 4); b_req_wdata = 16'h1000 + 16'(i);
            exp_d = (i < 4) ? 16'h0 : 16'h1000 + 16'(i % 4);
            k = 0;
            while (!b_req_ready && k < 10) begin tick(); k++; end
            tick();
            acc = cyc;
            if (i > 0) begin
                total++; if (acc - prev !== 3) $display("FAIL b2b_spacing item%0d got=%0d exp=3", i, acc - prev); else pass++;
            end
            prev = acc;
            tick();
            total++; if (b_rsp_valid !== 1'b1 || b_rsp_rdata !== exp_d || b_rsp_err !== 1'b0)
                $display("FAIL b2b_rsp item%0d got=%b/%h/%b exp=1/%h/0", i, b_rsp_valid, b_rsp_rdata, b_rsp_err, exp_d); else pass++;
        end
        b_req_valid = 1'b0;
        tick();
    endtask

    task automatic test_addr_error();
        int lat;
        a_xact(1'b1, 8'hC7, 16'h0042, lat); a_done();
        a_xact(1'b1, 8'hC8, 16'h1234, lat);
        total++; if (a_rsp_err !== 1'b1 || a_rsp_rdata !== 16'h0)
            $display("FAIL err_wr got=%b/%h exp=1/0000", a_rsp_err, a_rsp_rdata); else pass++;
        a_done();
        a_xact(1'b0, 8'hC7, 16'h0, lat);
        total++; if (a_rsp_err !== 1'b0 || a_rsp_rdata !== 16'h0042)
            $display("FAIL last_valid_rd got=%b/%h exp=0/0042", a_rsp_err, a_rsp_rdata); else pass++;
        a_done();
        a_xact(1'b0, 8'hC8, 16'h0, lat);
        total++; if (a_rsp_err !== 1'b1 || a_rsp_rdata !== 16'h0)
            $display("FAIL err_rd got=%b/%h exp=1/0000", a_rsp_err, a_rsp_rdata); else pass++;
        a_done();
    endtask

    task automatic test_reset_in_wait();
        int lat;
        a_xact(1'b1, 8'h20, 16'h5555, lat); a_done();
        a_req_we = 1'b1; a_req_addr = 8'h20; a_req_wdata = 16'hAAAA; a_req_valid = 1'b1;
        tick();
        a_req_valid = 1'b0;
        total++; if (a_busy !== 1'b1) $display("FAIL wait_busy got=%b exp=1", a_busy); else pass++;
        rst = 1'b1;
        tick();
        total++; if (a_busy !== 1'b0 || a_rsp_valid !== 1'b0)
            $display("FAIL rst_in_wait got=%b/%b exp=0/0", a_busy, a_rsp_valid); else pass++;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            total++; if (a_rsp_valid !== 1'b0) $display("FAIL dropped_rsp cyc%0d got=%b exp=0", i, a_rsp_valid); else pass++;
        end
        a_xact(1'b0, 8'h20, 16'h0, lat);
        total++; if (a_rsp_rdata !== 16'h5555) $display("FAIL discarded_write got=%h exp=5555", a_rsp_rdata); else pass++;
        a_done();
    endtask

    initial begin
        a_rsp_ready = 1'b0;
        b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = 8'h0; b_req_wdata = 16'h0; b_rsp_ready = 1'b0;
        test_reset();
        test_write_read();
        test_backpressure();
        test_back_to_back();
        test_addr_error();
        test_reset_in_wait();
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
